serial_magnitude_comparator: RTL

- Multi-cycle, parametrised magnitude comparator for two WIDTH-bit operands.
- Scans the operands MSB-first, DIGIT bits per clock, and terminates early at the first differing digit.
- Supports unsigned and two's-complement signed compare, selected per operation.
- Start/busy/done handshake; used where wide operands make a single-cycle comparator tree too slow or too large.

---
 rtl/serial_magnitude_comparator.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
//  Module     : serial_magnitude_comparator
//  Description: Digit-serial MSB-first magnitude comparator with early exit,
//               unsigned or two's-complement compare selected per operation.
//  Revision   : 1.0 - initial release
// ============================================================================
module serial_magnitude_comparator #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             a_gt_b,
   output logic             a_lt_b,
   output logic             a_eq_b
);

   localparam int c_ndig = WIDTH / DIGIT;
   localparam int c_cw   = (c_ndig > 1) ? $clog2(c_ndig) : 1;

   localparam logic [c_cw-1:0] c_last = c_cw'(c_ndig - 1);

   localparam logic [0:0] c_idle = 1'b0;
   localparam logic [0:0] c_run  = 1'b1;

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [c_cw-1:0]  r_cnt;

   logic [DIGIT-1:0] w_dig_a;
   logic [DIGIT-1:0] w_dig_b;
   logic [WIDTH-1:0] w_sa_next;
   logic [WIDTH-1:0] w_sb_next;
   logic [WIDTH-1:0] w_msb_flip;

   assign w_dig_a = r_sa[WIDTH-1 -: DIGIT];
   assign w_dig_b = r_sb[WIDTH-1 -: DIGIT];

   // Offset-binary mapping: flipping both sign bits turns a signed compare
   // into an unsigned one, so the scan datapath never sees signedness.
   assign w_msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

   generate
      if (DIGIT < WIDTH) begin : g_shift
         assign w_sa_next = {r_sa[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
         assign w_sb_next = {r_sb[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
      end else begin : g_noshift
         assign w_sa_next = '0;
         assign w_sb_next = '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_idle;
         r_sa    <= '0;
         r_sb    <= '0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         a_gt_b  <= 1'b0;
         a_lt_b  <= 1'b0;
         a_eq_b  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            c_idle: begin
               if (start) begin
                  r_sa    <= a ^ w_msb_flip;
                  r_sb    <= b ^ w_msb_flip;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= c_run;
               end
            end
            c_run: begin
               if (w_dig_a != w_dig_b) begin
                  a_gt_b  <= (w_dig_a > w_dig_b);
                  a_lt_b  <= ~(w_dig_a > w_dig_b);
                  a_eq_b  <= 1'b0;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= c_idle;
               end else if (r_cnt == c_last) begin
                  a_gt_b  <= 1'b0;
                  a_lt_b  <= 1'b0;
                  a_eq_b  <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= c_idle;
               end else begin
                  r_sa  <= w_sa_next;
                  r_sb  <= w_sb_next;
                  r_cnt <= r_cnt + c_cw'(1);
               end
            end
            default: begin
               r_state <= c_idle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
